// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter for asynchronous request levels: each bit is synchronized,
// edge-detected into a pending flag, and granted one at a time with a DONE/timeout release.
module sync_req_arbiter #(
    parameter int BUS_WIDTH  = 4,
    parameter int NUM_STAGES = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [BUS_WIDTH-1:0]         ASYNC_REQ,
    input  logic                         DONE,
    output logic [BUS_WIDTH-1:0]         GNT,
    output logic                         GNT_VLD,
    output logic [BUS_WIDTH-1:0]         PENDING,
    output logic                         TIMEOUT_ERR,
    output logic                         STATE,
    output logic [$clog2(BUS_WIDTH)-1:0] PTR
);

    localparam int PW = $clog2(BUS_WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    logic [BUS_WIDTH-1:0] sync_q [NUM_STAGES];
    logic [BUS_WIDTH-1:0] sreq;
    logic [BUS_WIDTH-1:0] sprev;
    logic [BUS_WIDTH-1:0] rise;

    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] gnt_q, gnt_d;
    logic                 gnt_vld_q, gnt_vld_d;
    logic [BUS_WIDTH-1:0] pending_q, pending_d;
    logic                 err_q, err_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        idx_q, idx_d;
    logic [BUS_WIDTH-1:0] clr;
    logic [PW-1:0]        next_ptr;

    logic                 found;
    logic [PW-1:0]        win_idx;
    int                   j;

    assign sreq = sync_q[NUM_STAGES-1];
    assign rise = sreq & ~sprev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < NUM_STAGES; s++) sync_q[s] <= '0;
            sprev <= '0;
        end else begin
            sync_q[0] <= ASYNC_REQ;
            for (int s = 1; s < NUM_STAGES; s++) sync_q[s] <= sync_q[s-1];
            sprev <= sreq;
        end
    end

    // First set pending bit at or above the pointer, wrapping around.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        j       = 0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            j = (int'(ptr_q) + i) % BUS_WIDTH;
            if (!found && pending_q[j]) begin
                found   = 1'b1;
                win_idx = PW'(j);
            end
        end
    end

    assign next_ptr = (idx_q == PW'(BUS_WIDTH - 1)) ? '0 : idx_q + PW'(1);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_vld_d = gnt_vld_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        clr       = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    clr       = BUS_WIDTH'(1) << win_idx;
                    gnt_d     = BUS_WIDTH'(1) << win_idx;
                    gnt_vld_d = 1'b1;
                    idx_d     = win_idx;
                    cnt_d     = '0;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                // DONE takes priority over a coincident timeout match.
                if (DONE || cnt_q == 8'(TIMEOUT)) begin
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    ptr_d     = next_ptr;
                    err_d     = ~DONE;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh edge on a bit being granted keeps it pending.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            pending_q <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
        end
    end

    assign GNT         = gnt_q;
    assign GNT_VLD     = gnt_vld_q;
    assign PENDING     = pending_q;
    assign TIMEOUT_ERR = err_q;
    assign STATE       = state_q;
    assign PTR         = ptr_q;

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Directed bench for sync_req_arbiter: expected grants are queued at stimulus time
// and a monitor pops one at every new grant; other outputs are checked inline.
module tb_sync_req_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] ASYNC_REQ;
    logic       DONE;
    logic [3:0] GNT;
    logic       GNT_VLD;
    logic [3:0] PENDING;
    logic       TIMEOUT_ERR;
    logic       STATE;
    logic [1:0] PTR;

    logic [3:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    sync_req_arbiter dut (
        .CLK(CLK), .RST(RST), .ASYNC_REQ(ASYNC_REQ), .DONE(DONE),
        .GNT(GNT), .GNT_VLD(GNT_VLD), .PENDING(PENDING),
        .TIMEOUT_ERR(TIMEOUT_ERR), .STATE(STATE), .PTR(PTR)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_grant(input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (GNT_VLD) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: no grant within 20 cycles, GNT_VLD=%0b expected 1", name, GNT_VLD);
        end
    endtask

    task automatic pulse_done();
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
    endtask

    // Monitor: every new grant must match the head of the expected queue.
    initial begin
        logic       prev_vld = 1'b0;
        logic [3:0] exp;
        forever begin
            @(posedge CLK);
            #2;
            if (GNT_VLD && !prev_vld) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL grant_order: got unexpected grant %b", GNT);
                end else begin
                    exp = exp_q.pop_front();
                    if (GNT !== exp) begin
                        n_err++;
                        $display("FAIL grant_order: got %b expected %b at %0t", GNT, exp, $time);
                    end
                end
            end
            prev_vld = GNT_VLD;
        end
    end

    initial begin
        int cycles;
        RST = 1'b1;
        ASYNC_REQ = '0;
        DONE = 1'b0;
        tick(3);
        check("reset_gnt", GNT, 4'b0000);
        check("reset_vld", GNT_VLD, 1'b0);
        check("reset_pending", PENDING, 4'b0000);
        check("reset_ptr", PTR, 2'd0);
        check("reset_err", TIMEOUT_ERR, 1'b0);
        check("reset_state", STATE, 1'b0);
        RST = 1'b0;
        tick();

        // DONE in IDLE is ignored
        pulse_done();
        check("idle_done_vld", GNT_VLD, 1'b0);
        check("idle_done_ptr", PTR, 2'd0);

        // Single request latency
        ASYNC_REQ = 4'b0001;
        exp_q.push_back(4'b0001);
        tick(2);
        check("lat_pending_e2", PENDING, 4'b0000);
        tick();
        check("lat_pending_e3", PENDING, 4'b0001);
        check("lat_gnt_e3", GNT, 4'b0000);
        tick();
        check("lat_gnt_e4", GNT, 4'b0001);
        check("lat_vld_e4", GNT_VLD, 1'b1);
        check("lat_pending_e4", PENDING, 4'b0000);
        pulse_done();
        check("rel_gnt", GNT, 4'b0000);
        check("rel_ptr", PTR, 2'd1);
        ASYNC_REQ = '0;
        tick(4);
        check("fall_no_pending", PENDING, 4'b0000);

        // All four at once, from pointer 0
        RST = 1'b1;
        tick();
        RST = 1'b0;
        ASYNC_REQ = 4'b1111;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        for (int k = 0; k < 4; k++) begin
            wait_grant("rr_grant");
            tick(2);
            pulse_done();
            check("rr_gap_vld", GNT_VLD, 1'b0);
        end
        check("rr_ptr", PTR, 2'd0);
        ASYNC_REQ = '0;
        tick(4);

        // Timeout on bit 2
        ASYNC_REQ = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_grant("to_grant");
        cycles = 1;
        for (int k = 0; k < 40 && GNT_VLD; k++) begin
            tick();
            if (GNT_VLD) cycles++;
        end
        check("to_cycles", cycles, 16);
        check("to_gnt", GNT, 4'b0000);
        check("to_err_pulse", TIMEOUT_ERR, 1'b1);
        check("to_ptr", PTR, 2'd3);
        tick();
        check("to_err_clear", TIMEOUT_ERR, 1'b0);
        ASYNC_REQ = '0;
        tick(4);

        // DONE coincident with timeout match
        ASYNC_REQ = 4'b0100;
        exp_q.push_back(4'b0100);
        wait_grant("tie_grant");
        tick(15);
        check("tie_still_granted", GNT, 4'b0100);
        pulse_done();
        check("tie_vld", GNT_VLD, 1'b0);
        check("tie_err", TIMEOUT_ERR, 1'b0);
        check("tie_ptr", PTR, 2'd3);
        tick();
        check("tie_err_after", TIMEOUT_ERR, 1'b0);
        ASYNC_REQ = '0;
        tick(4);

        // Reset mid-grant with PENDING=1010, requests held through release
        ASYNC_REQ = 4'b0001;
        exp_q.push_back(4'b0001);
        wait_grant("rst_grant");
        ASYNC_REQ = 4'b1011;
        tick(3);
        check("rst_pre_pending", PENDING, 4'b1010);
        check("rst_pre_gnt", GNT, 4'b0001);
        RST = 1'b1;
        tick();
        check("rst_gnt", GNT, 4'b0000);
        check("rst_vld", GNT_VLD, 1'b0);
        check("rst_pending", PENDING, 4'b0000);
        check("rst_ptr", PTR, 2'd0);
        check("rst_err", TIMEOUT_ERR, 1'b0);
        RST = 1'b0;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000);
        tick(2);
        check("rel_pending_e2", PENDING, 4'b0000);
        check("rel_gnt_e2", GNT_VLD, 1'b0);
        tick();
        check("rel_pending_e3", PENDING, 4'b1011);
        for (int k = 0; k < 3; k++) begin
            wait_grant("rel_grant");
            pulse_done();
        end
        tick(3);
        check("rel_once_pending", PENDING, 4'b0000);
        check("rel_once_vld", GNT_VLD, 1'b0);
        ASYNC_REQ = '0;
        tick(4);

        // Bit 1 re-requests during its own grant
        ASYNC_REQ = 4'b0010;
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0010);
        wait_grant("self_grant");
        ASYNC_REQ = 4'b0000;
        tick(3);
        ASYNC_REQ = 4'b0010;
        tick(3);
        check("self_pending", PENDING, 4'b0010);
        check("self_gnt_kept", GNT, 4'b0010);
        pulse_done();
        check("self_rel_vld", GNT_VLD, 1'b0);
        check("self_rel_pending", PENDING, 4'b0010);
        tick();
        check("self_regrant", GNT, 4'b0010);
        check("self_regrant_pending", PENDING, 4'b0000);
        pulse_done();
        tick(2);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_req_arbiter.md
SYNC_REQ_ARBITER -- requirements
Module: sync_req_arbiter

Interface
REQ-001 Parameter BUS_WIDTH, default 4: number of requesters; SHALL be 2..8.
REQ-002 Parameter NUM_STAGES, default 2: synchronizer depth per request bit; SHALL be 2..4.
REQ-003 Parameter TIMEOUT, default 15: maximum GRANT-state cycles without DONE; SHALL be 1..255.
REQ-004 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 RST  in  1  reset, synchronous and active-high.
REQ-006 ASYNC_REQ  in  BUS_WIDTH  asynchronous request levels, one bit per requester.
REQ-007 DONE  in  1  shared resource finished with current grant; synchronous to CLK.
REQ-008 GNT  out  BUS_WIDTH  registered one-hot grant; all-zero when no grant.
REQ-009 GNT_VLD  out  1  registered; high exactly when GNT is non-zero.
REQ-010 PENDING  out  BUS_WIDTH  registered latched-request flags.
REQ-011 TIMEOUT_ERR  out  1  registered one-cycle pulse on grant timeout.

Function
REQ-012 Each ASYNC_REQ bit SHALL pass through its own chain of NUM_STAGES flops; the last stage is SREQ[i].
REQ-013 A registered copy SPREV[i] of SREQ[i] SHALL be kept; rising edge = SREQ[i] & ~SPREV[i].
REQ-014 A rising edge on bit i SHALL set PENDING[i] at the next clock edge; falling edges and steady levels SHALL have no effect.
REQ-015 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-016 IDLE with PENDING non-zero: at the next edge, GNT = one-hot of the winner, GNT_VLD = 1, PENDING[winner] cleared, state -> GRANT.
REQ-017 Winner SHALL be the first set PENDING bit searching upward from pointer PTR, wrapping from BUS_WIDTH-1 to 0.
REQ-018 IDLE with PENDING zero: no change; GNT stays 0.
REQ-019 GRANT with DONE=1: at the next edge, GNT = 0, GNT_VLD = 0, PTR = (granted index + 1) mod BUS_WIDTH, state -> IDLE.
REQ-020 GNT_VLD SHALL be low for at least one cycle between consecutive grants.
REQ-021 An 8-bit timeout counter SHALL clear on entry to GRANT and increment each GRANT cycle with DONE=0.
REQ-022 If the counter equals TIMEOUT with DONE=0: at the next edge, state -> IDLE, GNT = 0, TIMEOUT_ERR = 1 for one cycle, PTR advances as in REQ-019.
REQ-023 DONE and timeout in the same cycle: DONE SHALL win; TIMEOUT_ERR SHALL stay 0.
REQ-024 DONE in IDLE SHALL be ignored.
REQ-025 If a new edge on bit i coincides with PENDING[i] being cleared by a grant, set SHALL win and PENDING[i] SHALL remain 1.
REQ-026 An edge on the currently granted bit during GRANT SHALL set PENDING for that bit; the active grant is unaffected.
REQ-027 Latency, idle arbiter, ASYNC_REQ[i] high before edge 1: SREQ[i] at edge NUM_STAGES, PENDING[i] at edge NUM_STAGES+1, GNT[i] at edge NUM_STAGES+2.

Reset
REQ-028 RST=1 at a clock edge SHALL clear all synchronizer stages, SPREV, PENDING, GNT, GNT_VLD, TIMEOUT_ERR, and the counter; PTR = 0; state = IDLE.
REQ-029 RST mid-grant SHALL drop GNT and GNT_VLD at that edge, with no TIMEOUT_ERR.
REQ-030 An ASYNC_REQ bit held high through reset release SHALL produce exactly one PENDING set, NUM_STAGES+1 edges after release.

Verification
REQ-031 NUM_STAGES=2, idle; ASYNC_REQ=4'b0001 -> PENDING=0001 after 3 edges, then GNT=0001/GNT_VLD=1 after 4 edges with PENDING=0000.
REQ-032 ASYNC_REQ=4'b1111 simultaneously, DONE pulsed 2 cycles after each grant -> grant order 0001, 0010, 0100, 1000, with GNT_VLD low one cycle between grants.
REQ-033 Grant on bit 2, DONE held 0 with TIMEOUT=15 -> GNT drops after 16 GRANT cycles, TIMEOUT_ERR high one cycle, PTR=3.
REQ-034 DONE=1 in the same cycle as the timeout match -> normal release, TIMEOUT_ERR=0.
REQ-035 RST=1 during GRANT with PENDING=1010 -> next cycle GNT=0, PENDING=0, PTR=0, no grant until a new edge.
REQ-036 ASYNC_REQ[1] toggled 0->1->0->1 during its own grant -> PENDING[1]=1 after release and bit 1 granted again in the next round-robin turn.
